epcs_byte_engine: RTL
=====================

Name: epcs_byte_engine

Overview:
- Downstream consumer of the STM32 bus bridge's flash-read channel (FLASH_enable / FLASH_continue_read / FLASH_data_out in; FLASH_data_in / FLASH_busy out).
- Runs a full-duplex SPI mode-0 byte transfer to the configuration serial flash (EPCS/ASx) for each request.
- Holds chip-select across consecutive bytes so the MCU can stream a command, the address and the read data.

Parameters:
- CLK_DIV, 2: DCLK half-period in clk_in cycles, legal range 1..255. SPI clock = clk_in / (2*CLK_DIV).

Ports:
- clk_in  in  1  system clock; the only clock in the block.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  session enable. A 0->1 edge starts the first byte; while 1, NCS stays low between bytes; 0 ends the session.
- continue_read  in  1  one-cycle-or-longer pulse that starts the next byte within a session.
- data_in  in  8  byte to shift out, sampled in the trigger cycle.
- data_out  out  8  last fully received byte.
- busy  out  1  transfer in progress. Includes the trigger cycle, combinationally.
- FLASH_NCS  out  1  flash chip select, active-low.
- FLASH_DCLK  out  1  SPI clock, idle low.
- FLASH_ASDO  out  1  MOSI, MSB first.
- FLASH_DATA0  in  1  MISO. Treated as synchronous to the DCLK produced here; no synchroniser.

Behaviour:
- Reset values (async, reset_n=0): NCS=1, DCLK=0, ASDO=0, data_out=0, busy=0, state=IDLE, enable_d=0, counters=0.
- Trigger:
  - start = (enable & ~enable_d & state==IDLE) | (enable & continue_read & state==HOLD).
  - enable_d is enable registered.
  - busy = start | (state in {SETUP, SHIFT_LO, SHIFT_HI}). busy is high in the trigger cycle itself, so a requester that samples busy one clock after asserting its request reads 1.
  - On a start edge, data_in is latched into tx_sr and the bit counter is cleared.
- States:
  - IDLE: NCS=1, DCLK=0. On enable rise -> SETUP.
  - SETUP: NCS=0. ASDO=tx_sr[7]. Lasts CLK_DIV cycles -> SHIFT_HI.
  - SHIFT_HI: DCLK=1 for CLK_DIV cycles. On entry, FLASH_DATA0 is shifted into rx_sr LSB. On exit: if bit count = 7 -> HOLD; else -> SHIFT_LO.
  - SHIFT_LO: DCLK=0 for CLK_DIV cycles. On entry, tx_sr shifts left and ASDO presents the next bit. Bit count increments. -> SHIFT_HI.
  - HOLD: NCS=0, DCLK=0. On entry, data_out <= rx_sr (single update per byte). A continue_read trigger latches data_in and goes to SHIFT_LO-equivalent setup: ASDO = new MSB, hold CLK_DIV cycles, -> SHIFT_HI.
- Latency:
  - First byte: trigger to data_out valid = CLK_DIV*(1+15)+1 cycles.
  - Each subsequent byte: 16*CLK_DIV+1 cycles.
  - Exactly 8 DCLK rising edges per byte.
- enable=0 in any non-IDLE state:
  - Next cycle: NCS=1, DCLK=0, ASDO=0, busy=0, state=IDLE.
  - data_out keeps its last complete value; a partial byte is discarded.
- continue_read while busy, or while enable=0: ignored, not queued.
- continue_read held high in HOLD for several cycles: only one byte starts. Retriggering needs HOLD again, i.e. level qualified by state.
- enable rise and continue_read high in the same cycle: one byte only.
- Asynchronous reset mid-transfer: outputs go to reset values immediately; no DCLK glitch other than forcing it low.
- All outputs are registered except busy, which is combinational per the formula above.

Test Plan:
- Command byte: CLK_DIV=2, data_in=0x03, enable rise.
  - busy=1 in the trigger cycle; NCS low.
  - ASDO sequence 0,0,0,0,0,0,1,1 on 8 DCLK rises.
  - busy falls after 33 cycles; NCS stays low in HOLD.
- Full duplex: flash model drives 0xA5 MSB-first. Issue continue_read with data_in=0x00.
  - data_out=0xA5 once busy falls; unchanged until the next byte completes.
- Bridge handshake: drive enable, then one cycle later assert continue_read.
  - A sampler one clock after each request always sees busy=1.
  - Stream 0x03, 0x00, 0x00, 0x00, then 4 dummies returning 0x11, 0x22, 0x33, 0x44: data_out reads these in order.
- Abort: drop enable after the 4th DCLK rise.
  - NCS=1 and busy=0 on the next cycle.
  - data_out retains the prior byte; a new enable rise restarts cleanly.
- Ignored request: pulse continue_read mid-byte, and separately with enable=0.
  - Exactly 8 DCLK rises occur; no extra byte starts.
- Reset: assert reset_n=0 mid-byte with CLK_DIV=1.
  - NCS=1, DCLK=0, data_out=0, busy=0 asynchronously.
  - After release, an enable rise completes a byte in 17 cycles.

Source files
------------

// File: rtl/epcs_byte_engine.sv
// -----------------------------------------------------------------------------
// epcs_byte_engine
//
// Purpose:
//   Byte-level SPI mode-0 master for the EPCS/ASx configuration flash. It sits
//   behind the STM32 bus bridge's flash-read channel. Each request shifts one
//   byte out on ASDO (MSB first) and, at the same time, shifts one byte in from
//   DATA0. Chip select stays low between bytes for as long as `enable` is high.
//   This lets the MCU stream a command, the address and then the read data
//   inside a single NCS session.
//
// Parameters:
//   CLK_DIV       DCLK half-period in clk_in cycles (1..255).
//                 The SPI clock runs at clk_in / (2*CLK_DIV).
//
// Ports:
//   clk_in        system clock
//   reset_n       asynchronous active-low reset
//   enable        session enable; a rising edge starts the first byte, and a
//                 low level ends the session
//   continue_read starts the next byte while the engine waits between bytes
//   data_in       byte to transmit, sampled in the trigger cycle
//   data_out      last completely received byte
//   busy          combinational; high from the trigger cycle until the byte ends
//   FLASH_NCS     flash chip select (active low)
//   FLASH_DCLK    SPI clock (idles low)
//   FLASH_ASDO    MOSI
//   FLASH_DATA0   MISO (synchronous to the DCLK generated here)
// -----------------------------------------------------------------------------
module epcs_byte_engine #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       continue_read,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       FLASH_NCS,
    output logic       FLASH_DCLK,
    output logic       FLASH_ASDO,
    input  logic       FLASH_DATA0
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETUP    = 3'd1;
    localparam logic [2:0] S_SHIFT_HI = 3'd2;
    localparam logic [2:0] S_SHIFT_LO = 3'd3;
    localparam logic [2:0] S_HOLD     = 3'd4;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [2:0] r_state;
    logic       r_enable_d;
    logic [7:0] r_div;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_tx_sr;
    logic [7:0] r_rx_sr;
    logic [7:0] r_data_out;
    logic       r_ncs;
    logic       r_dclk;
    logic       r_asdo;

    logic w_start_first;
    logic w_start_next;
    logic w_start;
    logic w_active;
    logic w_phase_end;

    // First byte: rising edge of enable while idle. Later bytes: continue_read
    // is qualified by HOLD, so a request that arrives mid-byte is dropped and
    // is not queued.
    assign w_start_first = enable & ~r_enable_d & (r_state == S_IDLE);
    assign w_start_next  = enable & continue_read & (r_state == S_HOLD);
    assign w_start       = w_start_first | w_start_next;
    assign w_active      = (r_state == S_SETUP) | (r_state == S_SHIFT_HI) |
                           (r_state == S_SHIFT_LO);
    assign w_phase_end   = (r_div == DIV_LAST);

    // busy includes the trigger cycle, so a requester that samples busy one
    // clock after its request always reads 1. While reset is held, busy is
    // forced low even if enable is already high.
    assign busy       = reset_n & (w_start | w_active);
    assign data_out   = r_data_out;
    assign FLASH_NCS  = r_ncs;
    assign FLASH_DCLK = r_dclk;
    assign FLASH_ASDO = r_asdo;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_enable_d <= 1'b0;
            r_div      <= 8'd0;
            r_bit_cnt  <= 3'd0;
            r_tx_sr    <= 8'd0;
            r_rx_sr    <= 8'd0;
            r_data_out <= 8'd0;
            r_ncs      <= 1'b1;
            r_dclk     <= 1'b0;
            r_asdo     <= 1'b0;
        end else begin
            r_enable_d <= enable;
            if (!enable) begin
                // Session end or abort: release the flash at once. A partial
                // byte in rx_sr is never copied to data_out.
                r_state   <= S_IDLE;
                r_ncs     <= 1'b1;
                r_dclk    <= 1'b0;
                r_asdo    <= 1'b0;
                r_div     <= 8'd0;
                r_bit_cnt <= 3'd0;
            end else if (w_start) begin
                // Latch the byte and present its MSB for one half-period
                // before the first rising edge.
                r_state   <= S_SETUP;
                r_tx_sr   <= data_in;
                r_bit_cnt <= 3'd0;
                r_div     <= 8'd0;
                r_ncs     <= 1'b0;
                r_dclk    <= 1'b0;
                r_asdo    <= data_in[7];
            end else begin
                case (r_state)
                    S_SETUP, S_SHIFT_LO: begin
                        if (w_phase_end) begin
                            // DCLK rises on this edge. DATA0 has been stable
                            // since the preceding falling edge, so it is
                            // sampled here.
                            r_state <= S_SHIFT_HI;
                            r_div   <= 8'd0;
                            r_dclk  <= 1'b1;
                            r_rx_sr <= {r_rx_sr[6:0], FLASH_DATA0};
                        end else begin
                            r_div <= r_div + 8'd1;
                        end
                    end
                    S_SHIFT_HI: begin
                        if (w_phase_end) begin
                            r_div  <= 8'd0;
                            r_dclk <= 1'b0;
                            if (r_bit_cnt == 3'd7) begin
                                r_state    <= S_HOLD;
                                r_data_out <= r_rx_sr;
                            end else begin
                                r_state   <= S_SHIFT_LO;
                                r_tx_sr   <= {r_tx_sr[6:0], 1'b0};
                                r_asdo    <= r_tx_sr[6];
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end else begin
                            r_div <= r_div + 8'd1;
                        end
                    end
                    S_IDLE, S_HOLD: begin
                        r_div <= 8'd0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_ncs   <= 1'b1;
                        r_dclk  <= 1'b0;
                        r_asdo  <= 1'b0;
                        r_div   <= 8'd0;
                    end
                endcase
            end
        end
    end

endmodule
